// File: rtl/dmadd_sequencer.sv
// Job-level controller for the DMADD min/max index search: clear, init, load, run, capture, result.
// Optional build macro DMADD_SKIP_EMPTY_EN: an empty mask bypasses DMADD and reports "not found" early.
module dmadd_sequencer #(
  parameter int N_ENTRIES  = 16,
  parameter int IDX_W      = 4,
  parameter int RUN_CYCLES = 16,
  parameter int OUT_W      = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_mode,
  input  logic [N_ENTRIES-1:0] cmd_mask,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_found,
  output logic [IDX_W-1:0]     res_index,
  output logic                 busy,
  output logic                 dm_rst_n,
  output logic                 dm_run,
  output logic                 dm_load,
  output logic [1:0]           dm_insn,
  output logic [IDX_W-1:0]     dm_index,
  output logic [3:0]           dm_data,
  input  logic [OUT_W-1:0]     dm_out
);

  localparam int CNT_MAX = (RUN_CYCLES > N_ENTRIES) ? RUN_CYCLES : N_ENTRIES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(N_ENTRIES - 1);
  localparam logic [CNT_W-1:0] LAST_RUN  = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_INIT,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_RESULT
`ifdef DMADD_SKIP_EMPTY_EN
    , S_SKIP
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [N_ENTRIES-1:0]  mask_q, mask_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_found_q, res_found_d;
  logic [IDX_W-1:0]      res_index_q, res_index_d;

  // DMADD only reports an index; its remaining result bits carry nothing this block needs.
  logic unused_dm_out_hi;
  assign unused_dm_out_hi = ^dm_out[OUT_W-1:IDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      mask_q      <= '0;
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      res_valid_q <= res_valid_d;
      res_found_q <= res_found_d;
      res_index_q <= res_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    res_valid_d = res_valid_q;
    res_found_d = res_found_q;
    res_index_d = res_index_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          mask_d  = cmd_mask;
          cnt_d   = '0;
          state_d = S_CLEAR;
`ifdef DMADD_SKIP_EMPTY_EN
          // Empty job: one settling slot, then report without touching DMADD.
          if (cmd_mask == '0) state_d = S_SKIP;
`endif
        end
      end
      S_CLEAR: state_d = S_INIT;
      S_INIT: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (cnt_q == LAST_LOAD) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_RUN) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        res_found_d = |mask_q;
        res_index_d = (|mask_q) ? dm_out[IDX_W-1:0] : '0;
        res_valid_d = 1'b1;
        state_d     = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef DMADD_SKIP_EMPTY_EN
      S_SKIP: state_d = S_CAPTURE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // DMADD reset follows the chip reset directly so DMADD is held cleared while we are.
  always_comb begin
    dm_rst_n = rst_n;
    dm_run   = 1'b0;
    dm_load  = 1'b0;
    dm_insn  = 2'b00;
    dm_index = '0;
    case (state_q)
      S_CLEAR: dm_rst_n = 1'b0;
      S_INIT:  dm_insn = {1'b0, mode_q};
      S_LOAD: begin
        dm_insn  = {1'b0, mode_q};
        dm_index = cnt_q[IDX_W-1:0];
        dm_load  = mask_q[cnt_q[IDX_W-1:0]];
      end
      S_RUN: begin
        dm_insn = {1'b0, mode_q};
        dm_run  = 1'b1;
      end
      default: ;
    endcase
  end

  assign dm_data   = 4'd0;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = res_valid_q;
  assign res_found = res_found_q;
  assign res_index = res_index_q;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Self-checking bench for dmadd_sequencer with a behavioural DMADD model and a reference search.
// Honours DMADD_SKIP_EMPTY_EN when computing expected latency for empty masks.
module tb_dmadd_sequencer;
  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int RUNC  = 16;
  localparam int OUT_W = 12;
  localparam int FULL_LAT = 3 + N + RUNC;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_mode;
  logic [N-1:0]     cmd_mask;
  logic             res_valid, res_ready, res_found;
  logic [IDX_W-1:0] res_index;
  logic             busy, dm_rst_n, dm_run, dm_load;
  logic [1:0]       dm_insn;
  logic [IDX_W-1:0] dm_index;
  logic [3:0]       dm_data;
  logic [OUT_W-1:0] dm_out;

  int checks = 0;
  int errors = 0;
  bit load_seen;

  dmadd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_mask(cmd_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found), .res_index(res_index),
    .busy(busy), .dm_rst_n(dm_rst_n), .dm_run(dm_run), .dm_load(dm_load),
    .dm_insn(dm_insn), .dm_index(dm_index), .dm_data(dm_data), .dm_out(dm_out)
  );

  always #5 clk = ~clk;

  // Behavioural DMADD: occupancy set, search on run; upper result bits are junk.
  logic [N-1:0]     occ;
  logic [OUT_W-1:0] out_r;
  int               mi;
  bit               mh;
  assign dm_out = out_r;

  always @(posedge clk) begin
    if (!dm_rst_n) occ <= '0;
    else if (dm_load) occ[dm_index] <= 1'b1;
    if (dm_run) begin
      mh = 1'b0;
      mi = 0;
      for (int i = 0; i < N; i++)
        if (occ[i]) begin
          if (dm_insn[0] || !mh) mi = i;
          mh = 1'b1;
        end
      out_r <= mh ? {OUT_W'($urandom) >> IDX_W, IDX_W'(mi)} : OUT_W'($urandom);
    end
  end

  always @(negedge clk) if (dm_load) load_seen = 1'b1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int exp_index(input bit mode, input logic [N-1:0] mask);
    logic [N-1:0] low;
    int v;
    if (mask == '0) return 0;
    if (!mode) begin
      low = mask & (~mask + 1'b1);
      return $clog2(low);
    end
    v = int'(mask) + 1;
    return $clog2(v) - 1;
  endfunction

  function automatic int exp_latency(input logic [N-1:0] mask);
`ifdef DMADD_SKIP_EMPTY_EN
    if (mask == '0) return 2;
`endif
    return FULL_LAT;
  endfunction

  task automatic start_job(input bit mode, input logic [N-1:0] mask);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("[TB] FAIL cmd_ready_wait got %0b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_mask  = mask;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_mode  = ~mode;
    cmd_mask  = N'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (res_valid) break;
    end
    if (!res_valid) begin
      checks++; errors++;
      $display("[TB] FAIL res_valid_timeout got 0 want 1 after %0d cycles", lat);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic run_job(input bit mode, input logic [N-1:0] mask, input int hold,
                         output bit found, output logic [IDX_W-1:0] idx, output int lat);
    start_job(mode, mask);
    wait_result(lat);
    found = res_found;
    idx   = res_index;
    repeat (hold) @(posedge clk);
    #1;
    handshake();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_mask = '0; res_ready = 1'b0;
    #3;
    checks++;
    if ({res_valid, res_found, res_index, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_res got %b want 0", {res_valid, res_found, res_index, busy});
    end
    checks++;
    if ({dm_rst_n, dm_run, dm_load, dm_insn, dm_index, dm_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dm got %b want 0", {dm_rst_n, dm_run, dm_load, dm_insn, dm_index, dm_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({dm_rst_n, cmd_ready, dm_run, dm_load} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %b want 1100", {dm_rst_n, cmd_ready, dm_run, dm_load});
    end
  endtask

  task automatic test_directed();
    bit               modes [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [N-1:0]     masks [4] = '{16'h0120, 16'h0120, 16'h0001, 16'h8000};
    bit               found;
    logic [IDX_W-1:0] idx, e;
    int               lat;
    for (int t = 0; t < 4; t++) begin
      run_job(modes[t], masks[t], 0, found, idx, lat);
      e = IDX_W'(exp_index(modes[t], masks[t]));
      checks++;
      if (found !== 1'b1 || idx !== e) begin
        errors++;
        $display("[TB] FAIL directed_%0d got found=%0b idx=%0d want found=1 idx=%0d", t, found, idx, e);
      end
      checks++;
      if (lat != FULL_LAT) begin
        errors++;
        $display("[TB] FAIL directed_lat_%0d got %0d want %0d", t, lat, FULL_LAT);
      end
    end
  endtask

  task automatic test_empty_mask();
    bit               found;
    logic [IDX_W-1:0] idx;
    int               lat;
    for (int m = 0; m < 2; m++) begin
      load_seen = 1'b0;
      run_job(m[0], '0, 0, found, idx, lat);
      checks++;
      if (found !== 1'b0 || idx !== '0 || load_seen) begin
        errors++;
        $display("[TB] FAIL empty_%0d got found=%0b idx=%0d load_seen=%0b want 0 0 0", m, found, idx, load_seen);
      end
      checks++;
      if (lat != exp_latency('0)) begin
        errors++;
        $display("[TB] FAIL empty_lat_%0d got %0d want %0d", m, lat, exp_latency('0));
      end
    end
  endtask

  task automatic test_result_hold();
    bit               f0;
    logic [IDX_W-1:0] i0;
    int               lat;
    start_job(1'b1, 16'h0120);
    wait_result(lat);
    f0 = res_found;
    i0 = res_index;
    checks++;
    if (f0 !== 1'b1 || i0 !== 4'd8) begin
      errors++;
      $display("[TB] FAIL hold_first got found=%0b idx=%0d want 1 8", f0, i0);
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_mask = 16'h0001;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checks++;
      if ({res_valid, res_found, res_index, cmd_ready, busy} !== {1'b1, f0, i0, 1'b0, 1'b1}) begin
        errors++;
        $display("[TB] FAIL hold_cycle_%0d got %b want %b", c,
                 {res_valid, res_found, res_index, cmd_ready, busy}, {1'b1, f0, i0, 1'b0, 1'b1});
      end
    end
    handshake();
    checks++;
    if ({res_valid, cmd_ready, busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL after_handshake got %b want 010", {res_valid, cmd_ready, busy});
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_res_ready got busy=%0b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_job();
    bit               found;
    logic [IDX_W-1:0] idx;
    int               lat;
    start_job(1'b0, 16'h0080);
    repeat (9) @(posedge clk);
    #2;
    checks++;
    if ({busy, dm_load, dm_index} !== {1'b1, 1'b1, 4'd7}) begin
      errors++;
      $display("[TB] FAIL pre_reset got %b want 1_1_0111", {busy, dm_load, dm_index});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, res_valid, res_found, res_index, dm_rst_n, dm_run, dm_load, dm_insn, dm_index} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset got %b want 0",
               {busy, res_valid, res_found, res_index, dm_rst_n, dm_run, dm_load, dm_insn, dm_index});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(1'b0, 16'h0400, 0, found, idx, lat);
    checks++;
    if (found !== 1'b1 || idx !== 4'd10 || lat != FULL_LAT) begin
      errors++;
      $display("[TB] FAIL post_reset_job got found=%0b idx=%0d lat=%0d want 1 10 %0d", found, idx, lat, FULL_LAT);
    end
  endtask

  task automatic test_dm_sequence();
    bit               mode;
    logic [N-1:0]     mask, one;
    logic [IDX_W-1:0] e;
    logic [8:0]       act, expv;
    bit               load_ph, run_ph, ins_ph;
    int               lat;
    one = 1;
    for (int j = 0; j < 2; j++) begin
      mode = j[0];
      mask = (j == 0) ? 16'hFFFF : (N'($urandom) | (one << $urandom_range(0, N - 1)));
      start_job(mode, mask);
      for (int cyc = 0; cyc < FULL_LAT - 1; cyc++) begin
        @(negedge clk);
        load_ph = (cyc >= 2) && (cyc < 2 + N);
        run_ph  = (cyc >= 2 + N) && (cyc < 2 + N + RUNC);
        ins_ph  = (cyc >= 1) && (cyc < 2 + N + RUNC);
        act  = {dm_rst_n, dm_run, dm_load, ins_ph ? dm_insn : 2'b00, load_ph ? dm_index : 4'd0};
        expv = {cyc != 0, run_ph, load_ph ? mask[cyc - 2] : 1'b0, ins_ph ? {1'b0, mode} : 2'b00,
                load_ph ? IDX_W'(cyc - 2) : 4'd0};
        checks++;
        if (act !== expv || dm_data !== 4'd0) begin
          errors++;
          $display("[TB] FAIL dm_seq_%0d_cyc%0d got %b data=%0d want %b data=0", j, cyc, act, dm_data, expv);
        end
      end
      wait_result(lat);
      e = IDX_W'(exp_index(mode, mask));
      checks++;
      if (res_found !== 1'b1 || res_index !== e) begin
        errors++;
        $display("[TB] FAIL dm_seq_res_%0d got found=%0b idx=%0d want 1 %0d", j, res_found, res_index, e);
      end
      handshake();
    end
  endtask

  task automatic test_random_jobs();
    bit               mode, found;
    logic [N-1:0]     mask;
    logic [IDX_W-1:0] idx, e;
    int               lat, sel;
    for (int t = 0; t < 12; t++) begin
      mode = 1'($urandom);
      sel  = $urandom_range(0, 3);
      case (sel)
        0: mask = N'($urandom);
        1: mask = N'($urandom) & N'($urandom) & N'($urandom);
        2: mask = N'(1) << $urandom_range(0, N - 1);
        default: mask = (t == 5) ? '0 : N'($urandom) & N'($urandom);
      endcase
      run_job(mode, mask, $urandom_range(0, 3), found, idx, lat);
      e = IDX_W'(exp_index(mode, mask));
      checks++;
      if (found !== (mask != '0) || idx !== e || lat != exp_latency(mask)) begin
        errors++;
        $display("[TB] FAIL random_%0d mode=%0b mask=%h got found=%0b idx=%0d lat=%0d want %0b %0d %0d",
                 t, mode, mask, found, idx, lat, mask != '0, e, exp_latency(mask));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_empty_mask();
    test_result_hold();
    test_reset_mid_job();
    test_dm_sequence();
    test_random_jobs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
